// File: rtl/alu_mc.sv
// alu_mc: registered, handshaked ALU for the MIPS-Lite EX stage.
// Single-cycle ops (AND/OR/ADD/SUB/SLT/NOR) return one cycle after accept;
// MULTU runs a WIDTH-step shift-add multiplier and returns {HI, LO}.
//
// Handshake (both sides): a transfer happens at a rising clk edge where
// valid && ready. The producer holds valid and its payload stable until that
// edge. in_ready never depends on in_valid, and out_valid/result are held
// until out_ready is seen at an edge.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             overflow,
  output logic [1:0]       dbg_state
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_AND   = 3'b000;
  localparam logic [2:0] OP_OR    = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_MULTU = 3'b011;
  localparam logic [2:0] OP_NOR   = 3'b100;
  localparam logic [2:0] OP_SUB   = 3'b110;
  localparam logic [2:0] OP_SLT   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_result_hi;
  logic             r_zero;
  logic             r_overflow;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;

  logic             w_accept;
  logic             w_is_sub;
  logic [WIDTH-1:0] w_b_op;
  logic [WIDTH:0]   w_sum;
  logic             w_carry_msb;
  logic             w_ovf_raw;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_ovf;
  logic [WIDTH:0]   w_mul_sum;

  assign in_ready  = (r_state == S_IDLE) && (!r_out_valid || out_ready);
  assign w_accept  = in_valid && in_ready;

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign result_hi = r_result_hi;
  assign zero      = r_zero;
  assign overflow  = r_overflow;
  assign dbg_state = r_state;

  // Shared adder for ADD/SUB/SLT plus the single-cycle result mux.
  always_comb begin
    w_is_sub    = (sel == OP_SUB) || (sel == OP_SLT);
    w_b_op      = w_is_sub ? ~b : b;
    w_sum       = {1'b0, a} + {1'b0, w_b_op} + {{WIDTH{1'b0}}, w_is_sub};
    w_carry_msb = a[WIDTH-1] ^ w_b_op[WIDTH-1] ^ w_sum[WIDTH-1];
    w_ovf_raw   = w_carry_msb ^ w_sum[WIDTH];
    w_alu_res   = '0;
    w_alu_ovf   = 1'b0;
    case (sel)
      OP_AND: w_alu_res = a & b;
      OP_OR:  w_alu_res = a | b;
      OP_NOR: w_alu_res = ~(a | b);
      OP_ADD, OP_SUB: begin
        w_alu_res = w_sum[WIDTH-1:0];
        w_alu_ovf = w_ovf_raw;
      end
      // Sign of a-b corrected by overflow gives the true signed compare.
      OP_SLT: w_alu_res = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_ovf_raw};
      default: w_alu_res = '0;
    endcase
  end

  // One shift-add step: conditionally add multiplicand into the upper half.
  always_comb begin
    w_mul_sum = {1'b0, r_acc} + (r_mplier[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
  end

  // Control FSM, multiplier datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_result_hi <= '0;
      r_zero      <= 1'b0;
      r_overflow  <= 1'b0;
      r_cnt       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (sel == OP_MULTU) begin
              r_state     <= S_MUL;
              r_out_valid <= 1'b0;
              r_mcand     <= a;
              r_mplier    <= b;
              r_acc       <= '0;
              r_cnt       <= '0;
            end else begin
              r_out_valid <= 1'b1;
              r_result    <= w_alu_res;
              r_result_hi <= '0;
              r_zero      <= (w_alu_res == '0);
              r_overflow  <= w_alu_ovf;
            end
          end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        S_MUL: begin
          // {acc, multiplier} shifts right with the step sum's carry on top.
          r_acc    <= w_mul_sum[WIDTH:1];
          r_mplier <= {w_mul_sum[0], r_mplier[WIDTH-1:1]};
          r_cnt    <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_result_hi <= w_mul_sum[WIDTH:1];
            r_result    <= {w_mul_sum[0], r_mplier[WIDTH-1:1]};
            r_zero      <= (w_mul_sum == '0) && (r_mplier[WIDTH-1:1] == '0);
            r_overflow  <= 1'b0;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed, table-driven bench for alu_mc (WIDTH=32 and WIDTH=8).
module tb_alu_mc;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  sel;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [31:0] result_hi;
  logic        zero;
  logic        overflow;
  logic [1:0]  dbg_state;

  logic        in_valid8;
  logic        in_ready8;
  logic [2:0]  sel8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        out_valid8;
  logic        out_ready8;
  logic [7:0]  result8;
  logic [7:0]  result_hi8;
  logic        zero8;
  logic        overflow8;
  logic [1:0]  dbg_state8;

  int checks;
  int failures;

  logic [31:0] exp_q[$];

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
    logic        ovf;
  } vec_t;

  vec_t vecs[12];

  alu_mc #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_hi(result_hi), .zero(zero), .overflow(overflow),
    .dbg_state(dbg_state)
  );

  alu_mc #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .sel(sel8), .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
    .result(result8), .result_hi(result_hi8), .zero(zero8), .overflow(overflow8),
    .dbg_state(dbg_state8)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    int early;
    int rdy_bad;
    int seen;
    logic [31:0] e;

    checks   = 0;
    failures = 0;

    vecs[0]  = '{3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1};
    vecs[1]  = '{3'b110, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0};
    vecs[2]  = '{3'b111, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0};
    vecs[3]  = '{3'b100, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[4]  = '{3'b111, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0};
    vecs[5]  = '{3'b000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1'b0};
    vecs[6]  = '{3'b001, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1'b0, 1'b0};
    vecs[7]  = '{3'b110, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[8]  = '{3'b110, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1};
    vecs[9]  = '{3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0};
    vecs[10] = '{3'b101, 32'h0000_0007, 32'h0000_0009, 32'h0000_0000, 1'b1, 1'b0};
    vecs[11] = '{3'b111, 32'h0000_0003, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; sel = '0; a = '0; b = '0; out_ready = 1'b1;
    in_valid8 = 1'b0; sel8 = '0; a8 = '0; b8 = '0; out_ready8 = 1'b1;
    repeat (3) step();

    // Reset state
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_result_hi", 64'(result_hi), 64'd0);
    chk("rst_zero", 64'(zero), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Back-to-back single-cycle ops, out_ready held high
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; sel = vecs[i].sel; a = vecs[i].a; b = vecs[i].b;
      exp_q.push_back(vecs[i].res);
      chk($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'd1);
      step();
      e = exp_q.pop_front();
      chk($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("v%0d_result", i), 64'(result), 64'(e));
      chk($sformatf("v%0d_zero", i), 64'(zero), 64'(vecs[i].zero));
      chk($sformatf("v%0d_overflow", i), 64'(overflow), 64'(vecs[i].ovf));
      chk($sformatf("v%0d_result_hi", i), 64'(result_hi), 64'd0);
    end
    in_valid = 1'b0;
    step();
    chk("drain_out_valid", 64'(out_valid), 64'd0);

    // MULTU 0xFFFFFFFF * 0xFFFFFFFF, output held under backpressure
    out_ready = 1'b0;
    in_valid = 1'b1; sel = 3'b011; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    chk("mul_in_ready", 64'(in_ready), 64'd1);
    step();
    sel = 3'b010; a = 32'h1234_5678; b = 32'h1;
    chk("mul_state", 64'(dbg_state), 64'd1);
    early = 0; rdy_bad = 0;
    for (int k = 1; k <= 32; k++) begin
      if (in_ready) rdy_bad++;
      if (out_valid) early++;
      step();
    end
    in_valid = 1'b0;
    chk("mul_in_ready_low", 64'(rdy_bad), 64'd0);
    chk("mul_early_valid", 64'(early), 64'd0);
    chk("mul_out_valid", 64'(out_valid), 64'd1);
    chk("mul_lo", 64'(result), 64'h0000_0001);
    chk("mul_hi", 64'(result_hi), 64'hFFFF_FFFE);
    chk("mul_zero", 64'(zero), 64'd0);
    chk("mul_overflow", 64'(overflow), 64'd0);
    chk("mul_done_in_ready", 64'(in_ready), 64'd0);
    repeat (2) step();
    chk("mul_hold_valid", 64'(out_valid), 64'd1);
    chk("mul_hold_lo", 64'(result), 64'h0000_0001);
    out_ready = 1'b1;
    step();
    chk("mul_consumed", 64'(out_valid), 64'd0);
    chk("mul_idle_ready", 64'(in_ready), 64'd1);

    // Backpressure: ADD 2+3 held while an OR waits, then both swap at one edge
    out_ready = 1'b0;
    in_valid = 1'b1; sel = 3'b010; a = 32'd2; b = 32'd3;
    step();
    sel = 3'b001; a = 32'h0000_F0F0; b = 32'h0000_FF00;
    rdy_bad = 0; early = 0;
    for (int k = 0; k < 5; k++) begin
      if (in_ready) rdy_bad++;
      if (!out_valid || result !== 32'd5) early++;
      step();
    end
    chk("bp_in_ready_low", 64'(rdy_bad), 64'd0);
    chk("bp_hold_bad", 64'(early), 64'd0);
    out_ready = 1'b1;
    #1;
    chk("bp_ready_on_consume", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    chk("bp_b2b_valid", 64'(out_valid), 64'd1);
    chk("bp_b2b_result", 64'(result), 64'h0000_FFF0);
    step();
    chk("bp_drain", 64'(out_valid), 64'd0);

    // Reset in the middle of MULTU 3*5
    in_valid = 1'b1; sel = 3'b011; a = 32'd3; b = 32'd5;
    step();
    in_valid = 1'b0;
    repeat (9) step();
    rst_n = 1'b0;
    step();
    chk("mrst_out_valid", 64'(out_valid), 64'd0);
    chk("mrst_result", 64'(result), 64'd0);
    chk("mrst_result_hi", 64'(result_hi), 64'd0);
    chk("mrst_state", 64'(dbg_state), 64'd0);
    rst_n = 1'b1;
    step();
    chk("mrst_in_ready", 64'(in_ready), 64'd1);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (out_valid) seen++;
      step();
    end
    chk("mrst_no_stale", 64'(seen), 64'd0);

    // WIDTH=8: MULTU 0xFF*0xFF after 8 cycles, and ADD overflow
    in_valid8 = 1'b1; sel8 = 3'b011; a8 = 8'hFF; b8 = 8'hFF;
    step();
    in_valid8 = 1'b0;
    early = 0;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1 && out_valid8) early++;
      step();
    end
    chk("w8_early_valid", 64'(early), 64'd0);
    chk("w8_out_valid", 64'(out_valid8), 64'd1);
    chk("w8_hi", 64'(result_hi8), 64'hFE);
    chk("w8_lo", 64'(result8), 64'h01);
    step();
    in_valid8 = 1'b1; sel8 = 3'b010; a8 = 8'h7F; b8 = 8'h01;
    step();
    in_valid8 = 1'b0;
    chk("w8_add_result", 64'(result8), 64'h80);
    chk("w8_add_overflow", 64'(overflow8), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, registered successor to the EX-stage combinational ALU of the MIPS-Lite pipeline.
- Keeps the 3-bit sel encoding for AND/OR/ADD/SUB and adds SLT, NOR and a multi-cycle unsigned multiply (MULTU, shift-add) producing HI/LO.
- Uses a valid/ready handshake on both sides, so the hazard unit can stall the pipeline while a multiply is in flight.

Parameters:
- WIDTH, 32, operand/result width in bits; legal range 4..64.
- CNT_W, $clog2(WIDTH)+1, width of the multiply step counter; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low.
- in_valid  input  1  request valid; sel/a/b are valid with it.
- in_ready  output  1  block accepts a request this cycle.
- sel  input  3  operation: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 100 NOR, 011 MULTU, 101 reserved.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result valid; held until consumed.
- out_ready  input  1  consumer takes the result this cycle.
- result  output  WIDTH  primary result; LO half for MULTU.
- result_hi  output  WIDTH  HI half for MULTU; 0 for all other ops.
- zero  output  1  (result == 0); for MULTU, 1 only when both HI and LO are 0.
- overflow  output  1  signed two's-complement overflow for ADD/SUB; 0 for all other ops.

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; out_valid, result, result_hi, zero, overflow, counter and multiplier registers all 0. in_ready is 1 in the cycle after reset releases.
- Reset wins over every other event, including a multiply mid-operation: the partial product is discarded and no out_valid is produced for it.
- Accept: a request is accepted when in_valid && in_ready at a clk edge; sel/a/b are sampled only then.
- in_ready = (state==IDLE) && (!out_valid || out_ready). This is combinational from state, out_valid and out_ready; there is no path from in_valid.
- Output hold: out_valid stays 1 with stable result/result_hi/zero/overflow until out_valid && out_ready at an edge. Then out_valid drops, unless a new single-cycle op is accepted at the same edge, in which case out_valid stays 1 with the new result (back-to-back, no bubble).
- Single-cycle ops (AND, OR, ADD, SUB, SLT, NOR, reserved): results are registered at the accepting edge, so out_valid is 1 in the next cycle (latency 1).
  - ADD: a+b mod 2^WIDTH.
  - SUB: a-b mod 2^WIDTH, computed as a + ~b + 1.
  - SLT: 1 if $signed(a) < $signed(b), else 0. It must be correct on overflow, i.e. set = sum[MSB] ^ overflow of a-b.
  - NOR: ~(a|b).
  - Reserved 101: result 0, zero 1, overflow 0. No error flag.
- Overflow: for ADD/SUB only, overflow = carry into MSB ^ carry out of MSB.
- MULTU state machine, states IDLE, MUL, DONE:
  - IDLE -> MUL on accepting sel=011: load multiplicand=a, multiplier=b, acc=0, cnt=0.
  - MUL: each edge adds the multiplicand to the upper half of acc when the multiplier LSB is 1, shifts {acc, multiplier} right 1, and increments cnt.
  - MUL -> DONE when cnt reaches WIDTH-1 at an edge, i.e. WIDTH steps in total. result_hi = acc upper, result = acc lower, overflow 0, out_valid 1.
  - out_valid is first 1 exactly WIDTH cycles after the accepting edge.
  - DONE -> IDLE when out_ready is 1 at an edge. No new request is accepted in that cycle (in_ready=0 while not IDLE).
  - in_ready is 0 throughout MUL and DONE; in_valid is ignored there.
- MULTU issued while an earlier single-cycle result is still held: not possible, because in_ready requires the output to be free or consumed that edge.
- Width rules: all arithmetic is unsigned modulo 2^WIDTH except the SLT compare and the overflow flag; the MULTU product is the full 2*WIDTH bits, unsigned.

Test Plan (WIDTH=32 unless noted):
- Reset mid-multiply: MULTU a=3, b=5 accepted, rst_n=0 on cycle 10 -> next cycle out_valid=0, in_ready=1 after release, all outputs 0, no stale result ever appears.
- Basic ops back-to-back, out_ready=1:
  - ADD 0x7FFFFFFF+1 -> result 0x80000000, overflow 1.
  - SUB 5-5 -> result 0, zero 1.
  - SLT 0x80000000,1 -> result 1.
  - NOR 0,0 -> 0xFFFFFFFF.
  - Each result appears 1 cycle after its accept, with no bubbles between them.
- SLT overflow corner: a=0x7FFFFFFF, b=0x80000000 -> result 0. Also AND 0xF0F0, 0xFF00 -> 0xF000; OR -> 0xFFF0.
- MULTU: a=0xFFFFFFFF, b=0xFFFFFFFF -> result_hi 0xFFFFFFFE, result 0x00000001 exactly 32 cycles after accept; in_ready 0 for all of cycles 1..32. At WIDTH=8, 0xFF*0xFF -> hi 0xFE, lo 0x01 after 8 cycles.
- Backpressure: ADD 2+3 with out_ready=0 for 5 cycles -> out_valid stays 1, result stays 5, in_ready stays 0. A request presented meanwhile is not accepted, and is accepted at the same edge that out_ready=1 consumes the 5.
- Reserved sel=101 with a=7, b=9 -> result 0, zero 1, result_hi 0, overflow 0, latency 1.
